// File: rtl/lifo_fifo_buffer.sv
// ---------------------------------------------------------------------------
// lifo_fifo_buffer
//
// Single-clock storage buffer that behaves as either a stack (LIFO) or a
// queue (FIFO), chosen at run time. Every push or pop completes in one
// cycle. The active mode can only change while the buffer is empty, so
// stored data is always read back in the order it was written under.
//
// Parameters
//   WIDTH      data word width in bits (>= 1)
//   DEPTH      number of entries, power of two, >= 2
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst_n      asynchronous active-low reset
//   ena        enable; when low every other control input is ignored
//   mode       requested mode, 0 = LIFO, 1 = FIFO (loaded only while empty)
//   flush      synchronous clear of the contents, highest priority
//   push       write din this cycle
//   pop        read one entry this cycle
//   din        push data
//   dout       last popped word (registered, holds between pops)
//   dout_valid one-cycle pulse, dout was updated by a successful pop
//   full       count == DEPTH
//   empty      count == 0
//   count      number of stored entries, 0..DEPTH
//   overflow   one-cycle pulse, a push was rejected
//   underflow  one-cycle pulse, a pop was rejected
//   mode_q     currently active mode
// ---------------------------------------------------------------------------
module lifo_fifo_buffer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       ena,
    input  logic                       mode,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       dout_valid,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow,
    output logic                       mode_q
);

    localparam int              AW         = $clog2(DEPTH);
    localparam logic [AW:0]     FULL_COUNT = (AW+1)'(DEPTH);

    // Storage array. Deliberately not reset: an entry is only ever read
    // after it has been written, so its power-up contents never escape.
    logic [WIDTH-1:0] mem [DEPTH];

    // Queue pointers. Only meaningful in FIFO mode; in LIFO mode the top of
    // stack is derived from count and both pointers sit at zero.
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Decoded per-cycle decisions, all based on the state before the edge.
    logic            op_en;
    logic            push_ok;
    logic            pop_ok;
    logic            push_rej;
    logic            pop_rej;
    logic            mode_load;
    logic [AW-1:0]   top_addr;
    logic [AW-1:0]   wr_addr;
    logic [AW-1:0]   rd_addr;
    logic [AW:0]     count_next;

    // Status flags are pure functions of the entry count.
    assign full  = (count == FULL_COUNT);
    assign empty = (count == '0);

    // Operation decode.
    //
    // A push is accepted when there is room, or when a pop in the same cycle
    // frees (FIFO) or replaces (LIFO) a slot. A full buffer with push and pop
    // together is therefore legal in both modes. On an empty buffer a
    // simultaneous pop is rejected but the push still goes through.
    //
    // The stack top lives at count-1. Taking that modulo 2**AW is safe:
    // when count == DEPTH the low AW bits are zero and the wrap lands on
    // DEPTH-1, which is exactly the top entry. In LIFO a push alone writes
    // one above the top; a push paired with an accepted pop overwrites the
    // top in place while the old top is read out.
    always_comb begin
        op_en      = ena && !flush;
        push_ok    = op_en && push && (!full || pop);
        pop_ok     = op_en && pop && !empty;
        push_rej   = op_en && push && full && !pop;
        pop_rej    = op_en && pop && empty;
        mode_load  = op_en && empty && !push;
        top_addr   = count[AW-1:0] - 1'b1;
        wr_addr    = '0;
        rd_addr    = '0;
        if (mode_q) begin
            wr_addr = wr_ptr;
            rd_addr = rd_ptr;
        end else begin
            wr_addr = pop_ok ? top_addr : count[AW-1:0];
            rd_addr = top_addr;
        end
        count_next = count + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
    end

    // Storage write port. The read in the control block below uses the
    // pre-edge contents, so a LIFO replace returns the old top word.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_addr] <= din;
        end
    end

    // Control and output registers.
    //
    // Pulses default low every cycle. Disabled cycles hold everything.
    // Flush empties the buffer and ignores any push/pop, leaving dout alone.
    // The pointers are also re-zeroed whenever a mode load is possible: the
    // buffer is empty then, so nothing is lost, and LIFO mode always starts
    // from a clean pointer pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
            mode_q     <= 1'b0;
        end else begin
            dout_valid <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
            if (ena) begin
                if (flush) begin
                    count  <= '0;
                    wr_ptr <= '0;
                    rd_ptr <= '0;
                end else begin
                    count     <= count_next;
                    overflow  <= push_rej;
                    underflow <= pop_rej;
                    if (pop_ok) begin
                        dout       <= mem[rd_addr];
                        dout_valid <= 1'b1;
                    end
                    if (mode_q) begin
                        if (push_ok) begin
                            wr_ptr <= wr_ptr + 1'b1;
                        end
                        if (pop_ok) begin
                            rd_ptr <= rd_ptr + 1'b1;
                        end
                    end
                    if (mode_load) begin
                        mode_q <= mode;
                        wr_ptr <= '0;
                        rd_ptr <= '0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_lifo_fifo_buffer.sv
// ---------------------------------------------------------------------------
// tb_lifo_fifo_buffer
//
// Directed bench for lifo_fifo_buffer (WIDTH=8, DEPTH=4). Expected pop data
// is queued by the stimulus as it is issued; a monitor pops the queue and
// compares every time the buffer presents dout_valid. Status flags and
// pulses are checked directly after each stimulus cycle.
// ---------------------------------------------------------------------------
module tb_lifo_fifo_buffer;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int AW    = $clog2(DEPTH);

    logic             clk;
    logic             rst_n;
    logic             ena;
    logic             mode;
    logic             flush;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             full;
    logic             empty;
    logic [AW:0]      count;
    logic             overflow;
    logic             underflow;
    logic             mode_q;

    int               compared;
    int               mismatched;
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] mon_exp;

    lifo_fifo_buffer #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .mode       (mode),
        .flush      (flush),
        .push       (push),
        .pop        (pop),
        .din        (din),
        .dout       (dout),
        .dout_valid (dout_valid),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .overflow   (overflow),
        .underflow  (underflow),
        .mode_q     (mode_q)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something wedges the run.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, limit 100000", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    // Scalar comparison shared by all direct status checks.
    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Drive one cycle of controls from the falling edge, then return the
    // inputs to an enabled idle state just after the rising edge.
    task automatic applyStimulus(input logic e, input logic f, input logic pu,
                                 input logic po, input logic [WIDTH-1:0] d);
        @(negedge clk);
        ena   = e;
        flush = f;
        push  = pu;
        pop   = po;
        din   = d;
        @(posedge clk);
        #1;
        ena   = 1'b1;
        flush = 1'b0;
        push  = 1'b0;
        pop   = 1'b0;
        din   = '0;
    endtask

    // Monitor: every dout_valid must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && dout_valid) begin
            compared++;
            if (exp_q.size() == 0) begin
                mismatched++;
                $display("[TB] FAIL unexpected_pop: got dout %02h, expected no output", dout);
            end else begin
                mon_exp = exp_q.pop_front();
                if (dout !== mon_exp) begin
                    mismatched++;
                    $display("[TB] FAIL pop_data: got %02h, expected %02h", dout, mon_exp);
                end
            end
        end
    end

    initial begin
        compared   = 0;
        mismatched = 0;
        rst_n      = 1'b0;
        ena        = 1'b1;
        mode       = 1'b0;
        flush      = 1'b0;
        push       = 1'b0;
        pop        = 1'b0;
        din        = '0;

        // Reset values.
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_count", count, 0);
        checkOutput("rst_empty", empty, 1);
        checkOutput("rst_full", full, 0);
        checkOutput("rst_dout", dout, 0);
        checkOutput("rst_valid", dout_valid, 0);
        checkOutput("rst_mode", mode_q, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset asserted between edges with data stored.
        applyStimulus(1, 0, 1, 0, 8'h11);
        applyStimulus(1, 0, 1, 0, 8'h22);
        checkOutput("pre_rst_count", count, 2);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_count", count, 0);
        checkOutput("midrst_empty", empty, 1);
        checkOutput("midrst_dout", dout, 0);
        checkOutput("midrst_mode", mode_q, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // LIFO fill, overflow, drain, underflow.
        applyStimulus(1, 0, 1, 0, 8'hA1);
        applyStimulus(1, 0, 1, 0, 8'hA2);
        applyStimulus(1, 0, 1, 0, 8'hA3);
        applyStimulus(1, 0, 1, 0, 8'hA4);
        checkOutput("lifo_full", full, 1);
        checkOutput("lifo_count4", count, 4);
        applyStimulus(1, 0, 1, 0, 8'hA5);
        checkOutput("lifo_overflow", overflow, 1);
        checkOutput("lifo_ovf_count", count, 4);
        applyStimulus(1, 0, 0, 0, 8'h00);
        checkOutput("ovf_pulse_end", overflow, 0);
        exp_q.push_back(8'hA4);
        applyStimulus(1, 0, 0, 1, 8'h00);
        exp_q.push_back(8'hA3);
        applyStimulus(1, 0, 0, 1, 8'h00);
        exp_q.push_back(8'hA2);
        applyStimulus(1, 0, 0, 1, 8'h00);
        exp_q.push_back(8'hA1);
        applyStimulus(1, 0, 0, 1, 8'h00);
        checkOutput("lifo_empty", empty, 1);
        applyStimulus(1, 0, 0, 1, 8'h00);
        checkOutput("lifo_underflow", underflow, 1);
        checkOutput("uf_no_valid", dout_valid, 0);
        checkOutput("uf_dout_hold", dout, 8'hA1);

        // FIFO with pointer wrap.
        mode = 1'b1;
        applyStimulus(1, 0, 0, 0, 8'h00);
        checkOutput("fifo_mode", mode_q, 1);
        applyStimulus(1, 0, 1, 0, 8'h01);
        applyStimulus(1, 0, 1, 0, 8'h02);
        applyStimulus(1, 0, 1, 0, 8'h03);
        applyStimulus(1, 0, 1, 0, 8'h04);
        checkOutput("fifo_full", full, 1);
        applyStimulus(1, 0, 1, 0, 8'hEE);
        checkOutput("fifo_overflow", overflow, 1);
        exp_q.push_back(8'h01);
        applyStimulus(1, 0, 0, 1, 8'h00);
        exp_q.push_back(8'h02);
        applyStimulus(1, 0, 0, 1, 8'h00);
        applyStimulus(1, 0, 1, 0, 8'h05);
        applyStimulus(1, 0, 1, 0, 8'h06);
        checkOutput("fifo_wrap_count", count, 4);
        exp_q.push_back(8'h03);
        applyStimulus(1, 0, 0, 1, 8'h00);
        exp_q.push_back(8'h04);
        applyStimulus(1, 0, 0, 1, 8'h00);
        exp_q.push_back(8'h05);
        applyStimulus(1, 0, 0, 1, 8'h00);
        exp_q.push_back(8'h06);
        applyStimulus(1, 0, 0, 1, 8'h00);
        checkOutput("fifo_drained", empty, 1);

        // FIFO simultaneous push and pop while full.
        applyStimulus(1, 0, 1, 0, 8'h01);
        applyStimulus(1, 0, 1, 0, 8'h02);
        applyStimulus(1, 0, 1, 0, 8'h03);
        applyStimulus(1, 0, 1, 0, 8'h04);
        exp_q.push_back(8'h01);
        applyStimulus(1, 0, 1, 1, 8'h09);
        checkOutput("fifo_pp_count", count, 4);
        checkOutput("fifo_pp_no_ovf", overflow, 0);
        exp_q.push_back(8'h02);
        applyStimulus(1, 0, 0, 1, 8'h00);
        exp_q.push_back(8'h03);
        applyStimulus(1, 0, 0, 1, 8'h00);
        exp_q.push_back(8'h04);
        applyStimulus(1, 0, 0, 1, 8'h00);
        exp_q.push_back(8'h09);
        applyStimulus(1, 0, 0, 1, 8'h00);

        // FIFO simultaneous push and pop on empty.
        applyStimulus(1, 0, 1, 1, 8'h77);
        checkOutput("fifo_pp_empty_uf", underflow, 1);
        checkOutput("fifo_pp_empty_count", count, 1);
        exp_q.push_back(8'h77);
        applyStimulus(1, 0, 0, 1, 8'h00);

        // Back to LIFO: replace top, then push and pop on empty.
        mode = 1'b0;
        applyStimulus(1, 0, 0, 0, 8'h00);
        checkOutput("lifo_mode", mode_q, 0);
        applyStimulus(1, 0, 1, 0, 8'h22);
        applyStimulus(1, 0, 1, 0, 8'h33);
        exp_q.push_back(8'h33);
        applyStimulus(1, 0, 1, 1, 8'h44);
        checkOutput("lifo_pp_count", count, 2);
        exp_q.push_back(8'h44);
        applyStimulus(1, 0, 0, 1, 8'h00);
        exp_q.push_back(8'h22);
        applyStimulus(1, 0, 0, 1, 8'h00);
        applyStimulus(1, 0, 1, 1, 8'h55);
        checkOutput("lifo_pp_empty_uf", underflow, 1);
        checkOutput("lifo_pp_empty_count", count, 1);

        // Mode lock while holding data.
        mode = 1'b1;
        applyStimulus(1, 0, 0, 0, 8'h00);
        checkOutput("mode_locked", mode_q, 0);
        exp_q.push_back(8'h55);
        applyStimulus(1, 0, 0, 1, 8'h00);
        checkOutput("mode_locked_pop", mode_q, 0);
        checkOutput("lock_empty", empty, 1);
        applyStimulus(1, 0, 0, 0, 8'h00);
        checkOutput("mode_released", mode_q, 1);

        // Flush and enable.
        applyStimulus(1, 0, 1, 0, 8'h61);
        applyStimulus(1, 0, 1, 0, 8'h62);
        applyStimulus(1, 0, 1, 0, 8'h63);
        checkOutput("pre_flush_count", count, 3);
        applyStimulus(1, 1, 1, 0, 8'h64);
        checkOutput("flush_count", count, 0);
        checkOutput("flush_no_ovf", overflow, 0);
        checkOutput("flush_empty", empty, 1);
        applyStimulus(1, 0, 1, 0, 8'h71);
        applyStimulus(0, 0, 1, 0, 8'h72);
        checkOutput("dis_push_count", count, 1);
        checkOutput("dis_push_ovf", overflow, 0);
        applyStimulus(0, 0, 0, 1, 8'h00);
        checkOutput("dis_pop_count", count, 1);
        checkOutput("dis_pop_valid", dout_valid, 0);
        checkOutput("dis_pop_uf", underflow, 0);
        exp_q.push_back(8'h71);
        applyStimulus(1, 0, 0, 1, 8'h00);
        checkOutput("final_empty", empty, 1);

        // Every queued expectation must have been consumed by the monitor.
        repeat (3) @(posedge clk);
        #1;
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL missing_pops: got %0d outstanding, expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
